// File: rtl/des_stim_seq.sv
// des_stim_seq: DES stimulus sequencer (plaintext/key/start, ciphertext capture, scope trigger); DES_STIM_CHAIN_EN chains ciphertext into the next plaintext.
// Latency: start 2 cycles after an enabled IDLE cycle; next start GAP_CYCLES+3 cycles after done_in.
// Backpressure: none; done_in is only accepted in WAIT, and a WAIT lasting TIMEOUT cycles sets a sticky fault.
module des_stim_seq #(
   parameter logic [63:0] KEY        = 64'h133457799BBCDFF1,
   parameter logic [63:0] PT_SEED    = 64'h0123456789ABCDEF,
   parameter int unsigned GAP_CYCLES = 1000,
   parameter int unsigned NUM_ENC    = 0,
   parameter int unsigned TIMEOUT    = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic [63:0] pt_out,
   output logic [63:0] key_out,
   output logic        start,
   input  logic        done_in,
   input  logic [63:0] ct_in,
   output logic [63:0] ct_last,
   output logic        trigger,
   output logic [15:0] enc_count,
   output logic        finished,
   output logic        fault
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      GAP   = 3'd4,
      HALT  = 3'd5
   } state_t;

   localparam int              WW        = $clog2(TIMEOUT + 1);
   localparam logic [63:0]     PT_INIT   = (PT_SEED == 64'h0) ? 64'h1 : PT_SEED;
   localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);
   localparam logic [19:0]     GAP_LAST  = 20'(GAP_CYCLES);
   localparam logic [15:0]     ENC_LIMIT = 16'(NUM_ENC);
   localparam bit              HAS_LIMIT = (NUM_ENC != 0);

   state_t          state;
   state_t          state_nxt;
   logic [WW-1:0]   wait_cnt;
   logic [19:0]     gap_cnt;
   logic            wait_hit;
   logic            gap_end;
   logic [63:0]     pt_next;

   assign key_out  = KEY;
   assign wait_hit = (state == WAIT) && (wait_cnt == WAIT_LAST);
   // GAP spends one extra cycle retiring the captured ciphertext before its idle count
   assign gap_end  = (state == GAP) && (gap_cnt == GAP_LAST);

`ifdef DES_STIM_CHAIN_EN
   assign pt_next = (ct_last == 64'h0) ? 64'h1 : ct_last;
`else
   assign pt_next = {pt_out[62:0], pt_out[63] ^ pt_out[62] ^ pt_out[60] ^ pt_out[59]};
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (enable && !fault) state_nxt = LOAD;
         LOAD:  state_nxt = START;
         START: state_nxt = WAIT;
         WAIT: begin
            if (done_in)       state_nxt = GAP;
            else if (wait_hit) state_nxt = IDLE;
         end
         GAP: begin
            if (gap_end) begin
               if (HAS_LIMIT && (enc_count == ENC_LIMIT)) state_nxt = HALT;
               else if (enable)                          state_nxt = LOAD;
               else                                      state_nxt = IDLE;
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         pt_out    <= PT_INIT;
         ct_last   <= 64'h0;
         start     <= 1'b0;
         trigger   <= 1'b0;
         enc_count <= 16'h0;
         finished  <= 1'b0;
         fault     <= 1'b0;
         wait_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         state    <= state_nxt;
         start    <= (state_nxt == START);
         trigger  <= (state_nxt == START) || (state_nxt == WAIT);
         finished <= (state_nxt == HALT);
         wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         gap_cnt  <= (state == GAP)  ? gap_cnt + 1'b1  : '0;

         if ((state == WAIT) && done_in) begin
            ct_last   <= ct_in;
            enc_count <= enc_count + 1'b1;
         end

         // done_in arriving on the last WAIT cycle beats the timeout
         if ((state == WAIT) && !done_in && wait_hit)
            fault <= 1'b1;

         if (gap_end)
            pt_out <= pt_next;
      end
   end

endmodule

// File: tb/tb_des_stim_seq.sv
// Directed bench for des_stim_seq: reset, run timing, plaintext stepping, halt, enable drop, timeout.
module tb_des_stim_seq;

   localparam logic [63:0] KEY_EXP = 64'h133457799BBCDFF1;
   localparam logic [63:0] CT1     = 64'hDEADBEEF00000001;
   localparam logic [63:0] CT2     = 64'hA5A5A5A5A5A5A5A5;
   localparam logic [63:0] CT3     = 64'h0;
   localparam logic [63:0] CT_DROP = 64'h0000000000001111;
   localparam logic [63:0] CT_EDGE = 64'h0F0F0F0F0F0F0F0F;

`ifdef DES_STIM_CHAIN_EN
   localparam logic [63:0] PT_2    = CT1;
   localparam logic [63:0] PT_3    = CT2;
   localparam logic [63:0] PT_4    = 64'h1;
   localparam logic [63:0] PT_DROP = CT_DROP;
`else
   localparam logic [63:0] PT_2    = 64'h2;
   localparam logic [63:0] PT_3    = 64'h4;
   localparam logic [63:0] PT_4    = 64'h8;
   localparam logic [63:0] PT_DROP = 64'h2;
`endif

   logic        clk;
   logic        rst;
   logic        enable;
   logic [63:0] pt_out;
   logic [63:0] key_out;
   logic        start;
   logic        done_in;
   logic [63:0] ct_in;
   logic [63:0] ct_last;
   logic        trigger;
   logic [15:0] enc_count;
   logic        finished;
   logic        fault;

   int tests = 0;
   int fails = 0;

   des_stim_seq #(
      .PT_SEED    (64'h0),
      .GAP_CYCLES (4),
      .NUM_ENC    (3),
      .TIMEOUT    (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .pt_out    (pt_out),
      .key_out   (key_out),
      .start     (start),
      .done_in   (done_in),
      .ct_in     (ct_in),
      .ct_last   (ct_last),
      .trigger   (trigger),
      .enc_count (enc_count),
      .finished  (finished),
      .fault     (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called in a START cycle; raises done_in lat cycles later and returns on the cycle after it.
   task automatic run_enc(input int lat, input logic [63:0] ct, output int trig);
      trig = trigger ? 1 : 0;
      for (int k = 1; k <= lat; k++) begin
         step();
         if (trigger) trig++;
         if (k == lat) begin
            done_in = 1'b1;
            ct_in   = ct;
         end
      end
      step();
      done_in = 1'b0;
      ct_in   = 64'h0;
   endtask

   task automatic wait_start(input int limit, output int n);
      n = 0;
      while (start !== 1'b1 && n < limit) begin
         step();
         n++;
      end
   endtask

   task automatic count_starts(input int cycles, output int cnt);
      cnt = 0;
      for (int k = 0; k < cycles; k++) begin
         step();
         if (start) cnt++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int trig;
      int n;
      int cnt;

      rst     = 1'b0;
      enable  = 1'b0;
      done_in = 1'b0;
      ct_in   = 64'h0;
      step();
      step();
      step();
      check("rst_pt",       pt_out,           64'h1);
      check("rst_key",      key_out,          KEY_EXP);
      check("rst_ct_last",  ct_last,          64'h0);
      check("rst_start",    64'(start),       64'h0);
      check("rst_trigger",  64'(trigger),     64'h0);
      check("rst_count",    64'(enc_count),   64'h0);
      check("rst_finished", 64'(finished),    64'h0);
      check("rst_fault",    64'(fault),       64'h0);

      // First enabled cycle: start appears two cycles later
      rst    = 1'b1;
      enable = 1'b1;
      step();
      check("load_no_start", 64'(start), 64'h0);
      step();
      check("start_pulse",   64'(start),   64'h1);
      check("start_trigger", 64'(trigger), 64'h1);
      check("start_pt",      pt_out,       64'h1);

      run_enc(16, CT1, trig);
      check("enc1_trig_cycles", 64'(trig),      64'd17);
      check("enc1_trig_low",    64'(trigger),   64'h0);
      check("enc1_ct_last",     ct_last,        CT1);
      check("enc1_count",       64'(enc_count), 64'd1);
      wait_start(20, n);
      check("enc1_restart_gap", 64'(n + 1),     64'd7);
      check("enc2_pt",          pt_out,         PT_2);

      run_enc(16, CT2, trig);
      check("enc2_ct_last",     ct_last,        CT2);
      check("enc2_count",       64'(enc_count), 64'd2);
      wait_start(20, n);
      check("enc2_restart_gap", 64'(n + 1),     64'd7);
      check("enc3_pt",          pt_out,         PT_3);

      run_enc(16, CT3, trig);
      check("enc3_count", 64'(enc_count), 64'd3);
      n = 0;
      while (!finished && n < 20) begin
         step();
         n++;
      end
      check("halt_delay",    64'(n),        64'd5);
      check("halt_finished", 64'(finished), 64'h1);
      check("halt_pt",       pt_out,        PT_4);
      count_starts(40, cnt);
      check("halt_no_start", 64'(cnt),      64'h0);

      // done_in outside WAIT must be ignored
      done_in = 1'b1;
      ct_in   = 64'hFFFFFFFFFFFFFFFF;
      step();
      done_in = 1'b0;
      ct_in   = 64'h0;
      step();
      check("stray_done_count", 64'(enc_count), 64'd3);
      check("stray_done_ct",    ct_last,        CT3);

      // Enable dropped mid-encryption: finishes, then idles
      do_reset();
      step();
      step();
      check("drop_start", 64'(start), 64'h1);
      enable = 1'b0;
      run_enc(10, CT_DROP, trig);
      check("drop_trig_cycles", 64'(trig),      64'd11);
      check("drop_count",       64'(enc_count), 64'd1);
      count_starts(30, cnt);
      check("drop_no_start",    64'(cnt),       64'h0);
      check("drop_pt",          pt_out,         PT_DROP);
      check("drop_finished",    64'(finished),  64'h0);

      // Timeout: no done_in for 32 WAIT cycles
      enable = 1'b1;
      step();
      step();
      check("to_start", 64'(start), 64'h1);
      for (int k = 0; k < 32; k++) step();
      check("to_trig_last_wait",  64'(trigger), 64'h1);
      check("to_fault_not_yet",   64'(fault),   64'h0);
      step();
      check("to_fault",           64'(fault),   64'h1);
      check("to_trig_low",        64'(trigger), 64'h0);
      count_starts(40, cnt);
      check("to_no_restart",      64'(cnt),     64'h0);
      check("to_fault_sticky",    64'(fault),   64'h1);

      // Reset clears fault; done_in on the 32nd WAIT cycle wins over timeout
      do_reset();
      check("edge_fault_cleared", 64'(fault), 64'h0);
      step();
      step();
      check("edge_start", 64'(start), 64'h1);
      run_enc(32, CT_EDGE, trig);
      check("edge_trig_cycles", 64'(trig),      64'd33);
      check("edge_no_fault",    64'(fault),     64'h0);
      check("edge_count",       64'(enc_count), 64'd1);
      check("edge_ct_last",     ct_last,        CT_EDGE);
      step();
      check("edge_no_fault_late", 64'(fault),   64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/des_stim_seq.md
Name: des_stim_seq

Overview:
- Stimulus sequencer directly upstream of the DES core on the MAX10 side-channel evaluation board.
- Generates the plaintext and key words and issues one start pulse per encryption.
- Waits for DES completion and captures the ciphertext.
- Drives the scope trigger window, and inserts a programmable quiet gap between encryptions so the scope can re-arm.

Parameters:
- KEY, 64'h133457799BBCDFF1, fixed DES key presented on key_out.
- PT_SEED, 64'h0123456789ABCDEF, plaintext after reset; a value of 0 is replaced by 64'h1.
- GAP_CYCLES, 1000, idle cycles between done_in and the next start (range 1..2^20-1).
- NUM_ENC, 0, number of encryptions before halting; 0 means run forever.
- TIMEOUT, 4096, maximum cycles spent in WAIT before a fault is flagged.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- enable  in  1  run request, level-sensitive
- pt_out  out  64  plaintext to DES
- key_out  out  64  key to DES, constant KEY
- start  out  1  one-cycle pulse that launches an encryption
- done_in  in  1  one-cycle pulse from DES when the ciphertext is valid
- ct_in  in  64  ciphertext from DES, valid when done_in=1
- ct_last  out  64  last captured ciphertext
- trigger  out  1  scope trigger, high for the whole encryption window
- enc_count  out  16  completed encryptions, wraps at 16'hFFFF->0
- finished  out  1  NUM_ENC reached
- fault  out  1  sticky WAIT timeout flag

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, pt_out=PT_SEED (or 64'h1 if the seed is 0), ct_last=0, start=0, trigger=0, enc_count=0, finished=0, fault=0, internal counters=0. Reset overrides everything, including mid-encryption.
- All outputs are registered. key_out is tied to KEY.
- States: IDLE, LOAD, START, WAIT, GAP, HALT.
- IDLE: go to LOAD when enable=1 and fault=0.
- LOAD: one cycle; pt_out is stable; go to START.
- START: start=1 for exactly this cycle; trigger rises in this same cycle; go to WAIT.
- WAIT:
  - trigger stays 1; a wait counter increments each cycle.
  - done_in=1: ct_last<=ct_in, enc_count++, trigger<=0 on the next cycle, go to GAP.
  - Counter reaches TIMEOUT without done_in: fault<=1, trigger<=0, go to IDLE. fault is cleared only by reset.
  - done_in and timeout in the same cycle: done_in wins, no fault.
- done_in outside WAIT is ignored (no capture, no count).
- GAP:
  - Counts GAP_CYCLES cycles. On the final cycle, pt_out advances to the next plaintext (see Optional Feature).
  - Then, in priority order:
    - NUM_ENC!=0 and enc_count==NUM_ENC → HALT;
    - else enable=1 → LOAD;
    - else → IDLE.
- HALT: finished=1; stays until reset.
- enable deasserted during LOAD/START/WAIT: the current encryption completes normally; the block returns to IDLE after GAP.
- Start-to-start period = GAP_CYCLES + DES latency + 3 cycles (LOAD, START, done cycle).
- Plaintext LFSR (default): next = {pt[62:0], pt[63]^pt[62]^pt[60]^pt[59]}. It never reaches 0 from a nonzero state.

Optional Feature:
- Macro: DES_STIM_CHAIN_EN
- Defined: at the end of GAP, next pt_out = ct_last (ciphertext chaining, ECB chained). If ct_last==0, 64'h1 is used instead.
- Undefined: next pt_out comes from the 64-bit LFSR above. ct_last is still captured and output.

Test Plan:
- Reset: rst=0 for 3 cycles with PT_SEED=0 → pt_out=64'h1, all other outputs 0, state IDLE. Release with enable=1 → start pulses exactly 2 cycles after the first enabled cycle.
- Basic run: GAP_CYCLES=4, DES model done_in 16 cycles after start, ct_in=64'hDEADBEEF00000001 → trigger high 17 cycles, ct_last captured, enc_count=1, next start 7 cycles after done_in.
- LFSR step: PT_SEED=64'h1, macro off → after the first GAP, pt_out=64'h2; after the second, 64'h4.
- Chaining: macro on, ct_in=64'hA5A5A5A5A5A5A5A5 → next pt_out=64'hA5A5A5A5A5A5A5A5. With ct_in=0 → next pt_out=64'h1.
- Halt / enable drop: NUM_ENC=3 → finished=1 after the 3rd done_in, no 4th start. Separately, dropping enable mid-WAIT → encryption completes, enc_count increments, block returns to IDLE.
- Timeout: TIMEOUT=32, done_in never asserted → fault=1 at cycle 32 of WAIT, trigger=0, no further starts despite enable=1. done_in coinciding with the 32nd cycle → no fault.
